// File: rtl/path_chk_pkg.sv
// Package: path_chk_pkg
// Purpose: shared types and helpers for the path capture checker.
//   chk_state_t : checker FSM states
//   LAT_MAX     : deepest supported launch-to-capture latency
//   sat_inc     : saturating increment for a counter of a given width
package path_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int LAT_MAX = 16;

  // Returns cnt+1, clamped at the all-ones value of a cnt_w-bit counter.
  // The caller narrows the 32-bit result back to its own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int cnt_w);
    logic [31:0] max_val;
    max_val = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    sat_inc = (cnt >= max_val) ? max_val : (cnt + 32'd1);
  endfunction

endpackage

// File: rtl/path_chk_delay_line.sv
// Module: path_chk_delay_line
// Purpose: DEPTH-deep shift register of the launched bit. It shifts on every
//   clock regardless of checker state, so the history is always a true
//   record of the most recent launches.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset, clears the history
//   launch_d in   bit launched this cycle
//   hist     out  [DEPTH-1:0]; hist[k] = launch_d delayed k+1 cycles
module path_chk_delay_line
  import path_chk_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch_d,
  output logic [DEPTH-1:0] hist
);

  logic [DEPTH-1:0] hist_q;
  logic [DEPTH-1:0] hist_d;

  // Oldest sample falls off the top; the new launch enters at bit 0.
  always_comb begin
    hist_d    = hist_q << 1;
    hist_d[0] = launch_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;

endmodule

// File: rtl/path_capture_checker.sv
// Module: path_capture_checker
// Purpose: capture-side checker for a launch flop and its buffered path.
//   After a start pulse it waits LAT cycles so the launch history holds only
//   post-start launches, then compares WINDOW samples of capture_d against
//   the launch delayed LAT cycles, and every sink_d bit against the launch
//   delayed one cycle. Results are held in DONE until the next start.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle pulse, honoured only in IDLE or DONE
//   launch_d        bit launched this cycle
//   capture_d       bit arriving at the far end of the buffered path
//   sink_d          [NSINK] bits seen by the direct fanout sinks
//   busy, done      registered state flags (ARM/CHECK, DONE)
//   pass            done with no capture and no sink mismatches
//   err_cnt         [CNT_W] saturating capture mismatch count
//   first_err_idx   [$clog2(WINDOW)] sample index of first capture mismatch, all-ones if none
//   sink_err_mask   [NSINK] sticky per-sink mismatch flags
module path_capture_checker
  import path_chk_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int WINDOW = 256,
  parameter int NSINK  = 10,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      launch_d,
  input  logic                      capture_d,
  input  logic [NSINK-1:0]          sink_d,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [$clog2(WINDOW)-1:0] first_err_idx,
  output logic [NSINK-1:0]          sink_err_mask
);

  localparam int IDX_W = $clog2(WINDOW);
  localparam int ARM_W = $clog2(LAT_MAX + 1);

  chk_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;
  logic [NSINK-1:0] sink_err_mask_q, sink_err_mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [LAT-1:0]   hist;
  logic             cap_mismatch;

  path_chk_delay_line #(
    .DEPTH (LAT)
  ) u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .launch_d (launch_d),
    .hist     (hist)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    arm_cnt_d       = arm_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    sink_err_mask_d = sink_err_mask_q;
    cap_mismatch    = capture_d ^ hist[LAT-1];

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = ARM;
          idx_d           = '0;
          arm_cnt_d       = '0;
          err_cnt_d       = '0;
          first_err_idx_d = '1;
          sink_err_mask_d = '0;
        end
      end
      ARM: begin
        if (arm_cnt_q == ARM_W'(LAT - 1)) begin
          state_d = CHECK;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (cap_mismatch) begin
          err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
          // err_cnt saturates but never returns to zero, so zero means no
          // mismatch yet; a flag is not needed even when idx can be all-ones.
          if (err_cnt_q == '0) begin
            first_err_idx_d = idx_q;
          end
        end
        sink_err_mask_d = sink_err_mask_q | (sink_d ^ {NSINK{hist[0]}});
        if (idx_q == IDX_W'(WINDOW - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flags are derived from next-state values so they register alongside
    // the state and never see a combinational path from the inputs.
    busy_d = (state_d == ARM) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_cnt_d == '0) && (sink_err_mask_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      arm_cnt_q       <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '1;
      sink_err_mask_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      arm_cnt_q       <= arm_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      sink_err_mask_q <= sink_err_mask_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign sink_err_mask = sink_err_mask_q;

endmodule

// File: tb/tb_path_capture_checker.sv
// Testbench: tb_path_capture_checker
// Purpose: directed checks of path_capture_checker using three instances:
//   a: LAT=1 WINDOW=256 CNT_W=16  (reset, clean, capture error, sink error)
//   b: LAT=1 WINDOW=32  CNT_W=4   (counter saturation)
//   c: LAT=3 WINDOW=16  CNT_W=16  (restart from DONE, ARM length)
// All instances share clock, reset and the random launch stream; the bench
// builds capture/sink inputs from its own record of past launches.
module tb_path_capture_checker;

  logic clk = 1'b0;
  logic rst;
  logic launch_d;

  logic       start_a, cap_a, busy_a, done_a, pass_a;
  logic [9:0] sink_a, mask_a;
  logic [15:0] err_a;
  logic [7:0] fidx_a;

  logic       start_b, cap_b, busy_b, done_b, pass_b;
  logic [9:0] sink_b, mask_b;
  logic [3:0] err_b;
  logic [4:0] fidx_b;

  logic       start_c, cap_c, busy_c, done_c, pass_c;
  logic [9:0] sink_c, mask_c;
  logic [15:0] err_c;
  logic [3:0] fidx_c;

  int errors;
  int checks;
  int cyc;
  int n0_a, n0_b, n0_c;
  int inv_lo_a, inv_hi_a, inv_lo_b, inv_hi_b, inv_lo_c, inv_hi_c;
  int sink_i0, sink_i1;
  int cnt;
  logic lh [0:3];

  always #5 clk = ~clk;

  path_capture_checker #(.LAT(1), .WINDOW(256), .NSINK(10), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .launch_d(launch_d), .capture_d(cap_a),
    .sink_d(sink_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_idx(fidx_a), .sink_err_mask(mask_a)
  );

  path_capture_checker #(.LAT(1), .WINDOW(32), .NSINK(10), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .launch_d(launch_d), .capture_d(cap_b),
    .sink_d(sink_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_idx(fidx_b), .sink_err_mask(mask_b)
  );

  path_capture_checker #(.LAT(3), .WINDOW(16), .NSINK(10), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .launch_d(launch_d), .capture_d(cap_c),
    .sink_d(sink_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
    .first_err_idx(fidx_c), .sink_err_mask(mask_c)
  );

  // One cycle of stimulus, driven at the falling edge. Sample index of a run
  // started in cycle n0 is cyc - n0 - LAT - 1.
  task automatic applyStimulus(input logic sa, input logic sb, input logic sc, input bit rec);
    int s_a, s_b, s_c;
    @(negedge clk);
    if (rec && sa) n0_a = cyc;
    if (rec && sb) n0_b = cyc;
    if (rec && sc) n0_c = cyc;
    for (int k = 3; k > 0; k--) lh[k] = lh[k-1];
    lh[0] = 1'($urandom_range(0, 1));
    s_a = cyc - n0_a - 2;
    s_b = cyc - n0_b - 2;
    s_c = cyc - n0_c - 4;
    launch_d = lh[0];
    start_a  = sa;
    start_b  = sb;
    start_c  = sc;
    cap_a    = lh[1] ^ ((s_a >= inv_lo_a) && (s_a <= inv_hi_a));
    cap_b    = lh[1] ^ ((s_b >= inv_lo_b) && (s_b <= inv_hi_b));
    cap_c    = lh[3] ^ ((s_c >= inv_lo_c) && (s_c <= inv_hi_c));
    sink_a   = {10{lh[1]}};
    if ((s_a == sink_i0) || (s_a == sink_i1)) sink_a[3] = ~sink_a[3];
    sink_b   = {10{lh[1]}};
    sink_c   = {10{lh[1]}};
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ticks until the chosen instance drops busy; cnt = cycles seen busy.
  // A start pulse is injected (and not recorded) at loop step ignore_at.
  task automatic runUntilDone(input int which, input int ignore_at, output int n);
    logic b;
    b = 1'b1;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      applyStimulus((which == 0) && (k == ignore_at), (which == 1) && (k == ignore_at),
                    (which == 2) && (k == ignore_at), 1'b0);
      b = (which == 0) ? busy_a : ((which == 1) ? busy_b : busy_c);
      if (!b) break;
      n++;
    end
    checkOutput("run_ends", 32'(b), 32'h0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    n0_a = 0; n0_b = 0; n0_c = 0;
    inv_lo_a = 1; inv_hi_a = 0; inv_lo_b = 1; inv_hi_b = 0; inv_lo_c = 1; inv_hi_c = 0;
    sink_i0 = -100; sink_i1 = -100;
    for (int k = 0; k < 4; k++) lh[k] = 1'b0;
    launch_d = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cap_a = 1'b0; cap_b = 1'b0; cap_c = 1'b0;
    sink_a = '0; sink_b = '0; sink_c = '0;
    rst = 1'b1;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_busy", 32'(busy_a), 32'h0);
    checkOutput("rst_done", 32'(done_a), 32'h0);
    checkOutput("rst_pass", 32'(pass_a), 32'h0);
    checkOutput("rst_err_cnt", 32'(err_a), 32'h0);
    checkOutput("rst_first_idx", 32'(fidx_a), 32'hFF);
    checkOutput("rst_mask", 32'(mask_a), 32'h0);

    // Clean run with a start pulse dropped into the middle of CHECK.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(0, 100, cnt);
    checkOutput("clean_busy_cycles", 32'(cnt), 32'd257);
    checkOutput("clean_done", 32'(done_a), 32'h1);
    checkOutput("clean_pass", 32'(pass_a), 32'h1);
    checkOutput("clean_err_cnt", 32'(err_a), 32'h0);
    checkOutput("clean_first_idx", 32'(fidx_a), 32'hFF);
    checkOutput("clean_mask", 32'(mask_a), 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_done_held", 32'(done_a), 32'h1);

    // Single capture error at sample 37.
    inv_lo_a = 37; inv_hi_a = 37;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(0, -1, cnt);
    inv_lo_a = 1; inv_hi_a = 0;
    checkOutput("caperr_busy_cycles", 32'(cnt), 32'd257);
    checkOutput("caperr_done", 32'(done_a), 32'h1);
    checkOutput("caperr_err_cnt", 32'(err_a), 32'h1);
    checkOutput("caperr_first_idx", 32'(fidx_a), 32'd37);
    checkOutput("caperr_pass", 32'(pass_a), 32'h0);
    checkOutput("caperr_mask", 32'(mask_a), 32'h0);

    // Sink 3 wrong at samples 10 and 200.
    sink_i0 = 10; sink_i1 = 200;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(0, -1, cnt);
    sink_i0 = -100; sink_i1 = -100;
    checkOutput("sinkerr_mask", 32'(mask_a), 32'h008);
    checkOutput("sinkerr_err_cnt", 32'(err_a), 32'h0);
    checkOutput("sinkerr_pass", 32'(pass_a), 32'h0);
    checkOutput("sinkerr_first_idx", 32'(fidx_a), 32'hFF);

    // Reset asserted mid-CHECK after five capture errors.
    inv_lo_a = 0; inv_hi_a = 4;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrun_err_cnt", 32'(err_a), 32'd5);
    checkOutput("midrun_busy", 32'(busy_a), 32'h1);
    checkOutput("midrun_first_idx", 32'(fidx_a), 32'h0);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy_a), 32'h0);
    checkOutput("async_rst_done", 32'(done_a), 32'h0);
    checkOutput("async_rst_err_cnt", 32'(err_a), 32'h0);
    checkOutput("async_rst_first_idx", 32'(fidx_a), 32'hFF);
    checkOutput("async_rst_mask", 32'(mask_a), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    inv_lo_a = 1; inv_hi_a = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_idle_busy", 32'(busy_a), 32'h0);

    // Saturation on the 4-bit counter.
    inv_lo_b = 0; inv_hi_b = 31;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    runUntilDone(1, -1, cnt);
    inv_lo_b = 1; inv_hi_b = 0;
    checkOutput("sat_busy_cycles", 32'(cnt), 32'd33);
    checkOutput("sat_done", 32'(done_b), 32'h1);
    checkOutput("sat_err_cnt", 32'(err_b), 32'hF);
    checkOutput("sat_first_idx", 32'(fidx_b), 32'h0);
    checkOutput("sat_pass", 32'(pass_b), 32'h0);

    // LAT=3: errored run, then restart from DONE.
    inv_lo_c = 2; inv_hi_c = 2;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    runUntilDone(2, -1, cnt);
    inv_lo_c = 1; inv_hi_c = 0;
    checkOutput("lat3_busy_cycles", 32'(cnt), 32'd19);
    checkOutput("lat3_err_cnt", 32'(err_c), 32'h1);
    checkOutput("lat3_first_idx", 32'(fidx_c), 32'd2);
    checkOutput("lat3_done", 32'(done_c), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_busy", 32'(busy_c), 32'h1);
    checkOutput("restart_done", 32'(done_c), 32'h0);
    checkOutput("restart_err_cleared", 32'(err_c), 32'h0);
    checkOutput("restart_first_idx", 32'(fidx_c), 32'hF);
    runUntilDone(2, -1, cnt);
    checkOutput("restart_busy_cycles", 32'(cnt + 1), 32'd19);
    checkOutput("restart_pass", 32'(pass_c), 32'h1);
    checkOutput("restart_err_cnt", 32'(err_c), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
